uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, for the codec/MIDI control path. It generalises the fixed 8N1 single-holding-register transmitter to support:
- configurable data width, parity and stop-bit count;
- a multi-entry FIFO, so the host can queue several bytes;
- status flags for level, busy and overrun.

Bit timing comes from an external one-cycle `shift` enable at the baud rate.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9, sent LSB first.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: number of FIFO entries; power of two, at least 2. `AW` = log2(`FIFO_DEPTH`).

- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  `DATA_BITS`  data word to enqueue.
- `load`  in  1  write strobe; enqueues `din` on a clock edge where it is high.
- `shift`  in  1  baud tick, one clock wide; advances the frame by one bit.
- `txd`  out  1  serial output, registered; idles at 1.
- `ready`  out  1  FIFO not empty, i.e. data is waiting to be sent.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `count`  out  `AW`+1  current FIFO occupancy.
- `busy`  out  1  a frame is in progress (state is not IDLE).
- `overrun`  out  1  one-cycle pulse when a `load` is dropped.
- `state`  out  3  current FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

## Operation
- Reset values: `txd`=1, `ready`=0, `full`=0, `count`=0, `busy`=0, `overrun`=0, `state`=IDLE. FIFO pointers are cleared; FIFO contents are don't-care.
- Reset mid-frame aborts the frame immediately. `txd` goes high asynchronously and all queued data is discarded.
- FIFO write:
  - `load` with the FIFO not full writes `din` and increments the write pointer. Pointers wrap modulo `FIFO_DEPTH`.
  - `load` while full with no pop on the same edge drops the word and pulses `overrun`.
  - `load` while full with a pop on the same edge is accepted; `count` stays unchanged.
- FIFO pop happens only on the edge that starts a frame. The start decision uses the pre-edge `count`, so a word loaded on that same edge cannot be popped on it.
- IDLE: when `shift`=1 and `count`>0, pop the head word into the shift register, compute parity, set `txd`=0, and go to START.
- START: on `shift`, drive data bit 0 and go to DATA with the bit counter at 0.
- DATA: on each `shift`, advance the bit counter and drive the next bit. After bit `DATA_BITS`-1 completes:
  - go to PARITY if `PARITY`≠0, driving even parity (XOR of data bits) or odd parity (its inverse);
  - otherwise go to STOP, driving 1.
- PARITY: on `shift`, drive 1 and go to STOP.
- STOP: lasts `STOP_BITS` `shift` ticks.
  - On the final tick, if `count`>0, pop the next word and go to START (back-to-back frames, no extra idle bit).
  - Otherwise go to IDLE with `txd`=1.
- Without a `shift` tick, every state holds and `txd` holds.
- Illegal `state` encodings return to IDLE on the next edge with `txd`=1.

## Timing
- `txd` changes only on edges where `shift`=1 (or on reset). Every bit lasts exactly one `shift` period.
- Latency: a word loaded into an empty FIFO while IDLE is sent as follows:
  - the earliest start bit appears on the edge of the first `shift` tick strictly after the `load` edge;
  - no start bit occurs on the `load` edge itself.
- Frame length in `shift` ticks = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`.
- `ready`, `full` and `count` are registered and update on the same edge as the push or pop.
- `busy` is high from the START edge through the final STOP tick edge.

## Test plan
- Default 8N1, load 0xA5, `shift` every 16 clocks -> `txd` per tick is 0,1,0,1,0,0,1,0,1,1, then idles at 1; `busy` covers 10 ticks.
- `PARITY`=1, then `PARITY`=2, load 0xA5 -> parity bit is 0 for even and 1 for odd; frame is 11 ticks.
- `DATA_BITS`=7, `STOP_BITS`=2, load 0x41 -> `txd` is 0,1,0,0,0,0,0,1,1,1; the frame is 10 ticks.
- `FIFO_DEPTH`=4: load 0x01..0x05 in consecutive clocks with no `shift` -> `count`=4, `full`=1, one `overrun` pulse on the fifth load, and 0x05 is never sent. Then run `shift` -> 0x01..0x04 are sent back-to-back with no idle bits, and `ready` falls at the last pop.
- When full, assert `load` on the same edge as a frame-start pop -> word accepted, `count` stays 4, no `overrun`.
- Assert `reset` during DATA of the second of three queued frames -> `txd`=1 and `count`=0 immediately. After release, with no loads, no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo: parametrised UART transmitter fed by a small FIFO.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 load,
    input  logic                 shift,
    output logic                 txd,
    output logic                 ready,
    output logic                 full,
    output logic [AW:0]          count,
    output logic                 busy,
    output logic                 overrun,
    output logic [2:0]           state
);

    localparam logic [2:0]    S_IDLE      = 3'd0;
    localparam logic [2:0]    S_START     = 3'd1;
    localparam logic [2:0]    S_DATA      = 3'd2;
    localparam logic [2:0]    S_PARITY    = 3'd3;
    localparam logic [2:0]    S_STOP      = 3'd4;
    localparam logic [3:0]    c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   c_DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE   = 1;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic                 r_overrun;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_nxt;
    logic [3:0]           r_bitcnt;
    logic [3:0]           w_bitcnt_nxt;
    logic                 r_stopcnt;
    logic                 w_stopcnt_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;

    logic                 w_has_data;
    logic                 w_stop_done;
    logic                 w_pop;
    logic                 w_push;
    logic [DATA_BITS-1:0] w_head;

    assign w_has_data  = (r_count != '0);
    assign w_stop_done = (r_stopcnt == c_LAST_STOP);
    assign w_head      = r_mem[r_rptr];
    // Pops only on a frame-start edge, judged on the pre-edge occupancy.
    assign w_pop  = shift && w_has_data &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_done));
    assign w_push = load && ((r_count != c_DEPTH) || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_txd     <= 1'b1;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_par     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_txd     <= w_txd_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_stopcnt <= w_stopcnt_nxt;
            r_par     <= w_par_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (shift && w_has_data) w_state_nxt = S_START;
            S_START:  if (shift) w_state_nxt = S_DATA;
            S_DATA:   if (shift && (r_bitcnt == c_LAST_BIT))
                          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (shift) w_state_nxt = S_STOP;
            S_STOP:   if (shift && w_stop_done)
                          w_state_nxt = w_has_data ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_txd_nxt     = r_txd;
        w_shreg_nxt   = r_shreg;
        w_bitcnt_nxt  = r_bitcnt;
        w_stopcnt_nxt = r_stopcnt;
        w_par_nxt     = r_par;
        if (r_state > S_STOP) begin
            w_txd_nxt = 1'b1;
        end else if (w_pop) begin
            w_shreg_nxt = w_head;
            w_par_nxt   = ^w_head;
            w_txd_nxt   = 1'b0;
        end else if (shift) begin
            case (r_state)
                S_IDLE: w_txd_nxt = 1'b1;
                S_START: begin
                    w_txd_nxt    = r_shreg[0];
                    w_bitcnt_nxt = '0;
                end
                S_DATA: begin
                    if (r_bitcnt == c_LAST_BIT) begin
                        w_stopcnt_nxt = 1'b0;
                        if (PARITY == 0)
                            w_txd_nxt = 1'b1;
                        else
                            w_txd_nxt = (PARITY == 2) ? ~r_par : r_par;
                    end else begin
                        // Shift register keeps the next bit to send at index 1.
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        w_txd_nxt    = r_shreg[1];
                        w_shreg_nxt  = r_shreg >> 1;
                    end
                end
                S_PARITY: begin
                    w_txd_nxt     = 1'b1;
                    w_stopcnt_nxt = 1'b0;
                end
                S_STOP: begin
                    w_stopcnt_nxt = r_stopcnt + 1'b1;
                    if (w_stop_done) w_txd_nxt = 1'b1;
                end
                default: w_txd_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            r_count   <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            r_overrun <= load && !w_push;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    assign txd     = r_txd;
    assign ready   = w_has_data;
    assign full    = (r_count == c_DEPTH);
    assign count   = r_count;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;
    assign state   = r_state;

endmodule
`default_nettype wire
